// File: rtl/cla_seq.sv
// cla_seq: multi-word adder sequencer built around one 32-bit carry-lookahead
// adder (cla32). Wide operands of WORDS x 32 bits are added one word per
// clock, least-significant word first, with the carry chained through a
// register between words.
//
// Build option: define CLA_SEQ_SUB_EN to compile in subtract support
// (op=1 computes a - b as a + ~b + 1). Without it, op is ignored and every
// operation is a + b + ci.

// -----------------------------------------------------------------------------
// cla32: purely combinational 32-bit carry-lookahead adder.
// Three lookahead levels: 4-bit groups, super-groups of four groups, and a
// top level spanning the two super-groups.
// -----------------------------------------------------------------------------
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);

    // Four-position lookahead: returns the carries into positions 0..3 and
    // the carry out of position 3 (bit 4), all as flat sum-of-products.
    function automatic logic [4:0] lookahead4(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       c0
    );
        logic [4:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    logic [31:0] p_bit;
    logic [31:0] g_bit;
    logic [31:0] c_bit;
    logic [7:0]  g_grp;
    logic [7:0]  p_grp;
    logic [7:0]  c_grp;
    logic [1:0]  g_sup;
    logic [1:0]  p_sup;
    logic [4:0]  c_sup;
    logic [4:0]  la;

    // Generate/propagate at each level, then push carries back down.
    // NOTE: every variable gets an unconditional value before any use so the
    // block stays purely combinational and no latch is inferred.
    always_comb begin
        p_bit = a ^ b;
        g_bit = a & b;
        c_bit = '0;
        g_grp = '0;
        p_grp = '0;
        c_grp = '0;
        g_sup = '0;
        p_sup = '0;
        la    = '0;

        // Level 1: group generate/propagate over each 4-bit slice.
        for (int j = 0; j < 8; j++) begin
            la       = lookahead4(g_bit[4*j +: 4], p_bit[4*j +: 4], 1'b0);
            g_grp[j] = la[4];
            p_grp[j] = &p_bit[4*j +: 4];
        end

        // Level 2: super-group generate/propagate over four groups each.
        for (int k = 0; k < 2; k++) begin
            la       = lookahead4(g_grp[4*k +: 4], p_grp[4*k +: 4], 1'b0);
            g_sup[k] = la[4];
            p_sup[k] = &p_grp[4*k +: 4];
        end

        // Top level: carries into each super-group and the final carry out.
        c_sup = lookahead4({2'b00, g_sup}, {2'b00, p_sup}, ci);

        // Carries into each group from its super-group carry.
        for (int k = 0; k < 2; k++) begin
            la               = lookahead4(g_grp[4*k +: 4], p_grp[4*k +: 4], c_sup[k]);
            c_grp[4*k +: 4]  = la[3:0];
        end

        // Carries into each bit from its group carry.
        for (int j = 0; j < 8; j++) begin
            la               = lookahead4(g_bit[4*j +: 4], p_bit[4*j +: 4], c_grp[j]);
            c_bit[4*j +: 4]  = la[3:0];
        end

        s  = p_bit ^ c_bit;
        co = c_sup[2];
    end

endmodule

// -----------------------------------------------------------------------------
// cla_seq: word-serial wide adder controller.
// -----------------------------------------------------------------------------
module cla_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [32*WORDS-1:0]   a,
    input  logic [32*WORDS-1:0]   b,
    input  logic                  ci,
    output logic                  busy,
    output logic                  done,
    output logic [32*WORDS-1:0]   s,
    output logic                  co
);

    localparam int                IDX_W    = $clog2(WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [32*WORDS-1:0]  a_q;
    logic [32*WORDS-1:0]  b_q;
    logic                 carry_q;
    logic [IDX_W-1:0]     idx;

    logic [31:0]          a_word;
    logic [31:0]          b_word;
    logic [31:0]          sum_word;
    logic                 sum_co;
    logic                 carry_init;
    logic                 last_word;

`ifdef CLA_SEQ_SUB_EN
    logic                 op_q;
`else
    // op stays on the interface for a uniform port list but drives nothing.
    logic                 unused_op;
    assign unused_op = op;
`endif

    assign last_word = (idx == LAST_IDX);

    // Select the current word of each operand; invert B for a subtract.
    // {idx, 5'b0} is idx*32 at exactly the width needed to address the bus.
    always_comb begin
        a_word = a_q[{idx, 5'b0} +: 32];
        b_word = b_q[{idx, 5'b0} +: 32];
`ifdef CLA_SEQ_SUB_EN
        if (op_q) begin
            b_word = ~b_word;
        end
`endif
    end

    // Initial carry: ci for an add, forced to 1 for a subtract (two's complement).
    always_comb begin
`ifdef CLA_SEQ_SUB_EN
        carry_init = op ? 1'b1 : ci;
`else
        carry_init = ci;
`endif
    end

    cla32 u_cla32 (
        .a  (a_word),
        .b  (b_word),
        .ci (carry_q),
        .s  (sum_word),
        .co (sum_co)
    );

    // State register.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start)     state_nxt = S_ADD;
            S_ADD:   if (last_word) state_nxt = S_DONE;
            S_DONE:                 state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from state only; no input-to-output path.
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Operand capture, word loop and result registers.
    // NOTE: the operand and result registers are wide but are plain flops, not
    // a RAM, so they take the async reset and come up as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            s       <= '0;
            co      <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            op_q    <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= carry_init;
                        idx     <= '0;
`ifdef CLA_SEQ_SUB_EN
                        op_q    <= op;
`endif
                    end
                end
                S_ADD: begin
                    s[{idx, 5'b0} +: 32] <= sum_word;
                    carry_q              <= sum_co;
                    if (last_word) begin
                        co <= sum_co;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq.sv
// Self-checking bench for cla_seq: directed corner cases plus randomized
// operations compared against a plain wide-arithmetic reference model.
// Honours CLA_SEQ_SUB_EN the same way the design does.
module tb_cla_seq;

    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ci;
    logic          busy;
    logic          done;
    logic [W-1:0]  s;
    logic          co;

    int errors    = 0;
    int checks    = 0;
    int done_seen = 0;

    cla_seq #(.WORDS(WORDS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .ci      (ci),
        .busy    (busy),
        .done    (done),
        .s       (s),
        .co      (co)
    );

    always #5 clk = ~clk;

    // Count done cycles, sampled away from the active edge.
    always @(negedge clk) if (done) done_seen++;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {co, s} from plain wide arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                         input logic ci_i, input logic op_i);
        logic sub;
        sub = op_i;
`ifndef CLA_SEQ_SUB_EN
        sub = 1'b0;
`endif
        if (sub) return {(a_i >= b_i), a_i - b_i};
        return {1'b0, a_i} + {1'b0, b_i} + (W+1)'(ci_i);
    endfunction

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        for (int w = 0; w < WORDS; w++) v[32*w +: 32] = $urandom();
        return v;
    endfunction

    // Issue one start from a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                            input logic ci_i, input logic op_i);
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_before_start", W'(busy), W'(0));
        a = a_i; b = b_i; ci = ci_i; op = op_i; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs: the operation must run from its captured copies.
        a = rand_wide(); b = rand_wide(); ci = 1'($urandom()); op = 1'($urandom());
        check("busy_after_accept", W'(busy), W'(1));
    endtask

    // Wait for done, checking latency (cycles remaining) and the result.
    task automatic finish_op(input string tag, input int lat, input logic [W:0] exp);
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, W'(n), W'(lat));
        check({tag, "_s"}, s, exp[W-1:0]);
        check({tag, "_co"}, W'(co), W'(exp[W]));
        @(negedge clk);
        check({tag, "_done_falls"}, W'(done), W'(0));
        check({tag, "_busy_falls"}, W'(busy), W'(0));
    endtask

    logic [W-1:0] ta, tb_v;
    logic         tci, top;
    int           d0;

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0; ci = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_s", s, W'(0));
        check("rst_co", W'(co), W'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Carry ripples across three word boundaries.
        ta = {32'h0, {3{32'hFFFF_FFFF}}};
        start_op(ta, W'(1), 1'b0, 1'b0);
        finish_op("ripple", WORDS, {1'b0, 32'h1, 96'h0});

        // Full-width overflow.
        start_op({W{1'b1}}, W'(0), 1'b1, 1'b0);
        finish_op("overflow", WORDS, {1'b1, W'(0)});

        // A second start while busy is ignored.
        d0 = done_seen;
        ta = rand_wide(); tb_v = rand_wide();
        start_op(ta, tb_v, 1'b1, 1'b0);
        @(negedge clk);
        a = rand_wide(); b = rand_wide(); ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_op("busy_start", WORDS - 2, model(ta, tb_v, 1'b1, 1'b0));
        repeat (8) @(negedge clk);
        check("busy_start_no_activity", W'(busy), W'(0));
        check("busy_start_one_done", W'(done_seen - d0), W'(1));

        // Asynchronous reset in the middle of the word loop.
        start_op(rand_wide(), rand_wide(), 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_done", W'(done), W'(0));
        check("midrst_s", s, W'(0));
        check("midrst_co", W'(co), W'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_op(W'(5), W'(7), 1'b0, 1'b0);
        finish_op("after_rst", WORDS, {1'b0, W'(12)});

        // op=1: subtract when compiled in, plain add otherwise.
`ifdef CLA_SEQ_SUB_EN
        start_op(W'(0), W'(1), 1'b0, 1'b1);
        finish_op("sub_borrow", WORDS, {1'b0, {W{1'b1}}});
`else
        start_op(W'(5), W'(3), 1'b0, 1'b1);
        finish_op("op_ignored", WORDS, {1'b0, W'(8)});
`endif

        // Randomized operations, some biased toward long carry chains.
        for (int i = 0; i < 30; i++) begin
            ta   = rand_wide();
            tb_v = (i % 3 == 0) ? ~ta : rand_wide();
            tci  = 1'($urandom());
            top  = 1'($urandom());
            start_op(ta, tb_v, tci, top);
            finish_op($sformatf("rand%0d", i), WORDS, model(ta, tb_v, tci, top));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
